// File: rtl/alu_operand_loader.sv
// Operand loader for the ALU op units. One load button captures operand A, operand B and
// the opcode in turn from the switches, then offers the set on a valid/ready handshake.
// Define DEBOUNCE_EN to insert a debounce filter on the synchronized button level.
module alu_operand_loader #(
  parameter int N          = 4,
  parameter int OPW        = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   sw_data,
  input  logic           btn_load,
  input  logic           clear,
  input  logic           alu_ready,
  output logic [N-1:0]   op_a,
  output logic [N-1:0]   op_b,
  output logic [OPW-1:0] opcode,
  output logic           op_valid,
  output logic [1:0]     stage
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    ISSUE   = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           r_sync1;
  logic           r_sync2;
  logic           r_prev;
  logic           w_level;
  logic           w_press;
  logic           w_cap_a;
  logic           w_cap_b;
  logic           w_cap_op;
  logic [N-1:0]   r_op_a;
  logic [N-1:0]   r_op_b;
  logic [OPW-1:0] r_opcode;

  // The button is asynchronous to clk: two flops settle it, a third holds the last level
  // so a held button yields a single press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= btn_load;
      r_sync2 <= r_sync1;
      r_prev  <= w_level;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES);

  logic          r_deb;
  logic [CW-1:0] r_deb_cnt;

  // The debounced level only follows s2 after it has differed for DEB_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == CW'(DEB_CYCLES - 1)) begin
      r_deb     <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + CW'(1);
    end
  end

  assign w_level = r_deb;
`else
  logic w_unused_deb;

  assign w_unused_deb = (DEB_CYCLES > 1);
  assign w_level      = r_sync2;
`endif

  assign w_press = w_level & ~r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = WAIT_A;
    end else begin
      case (r_state)
        WAIT_A:  if (w_press)   w_state_next = WAIT_B;
        WAIT_B:  if (w_press)   w_state_next = WAIT_OP;
        WAIT_OP: if (w_press)   w_state_next = ISSUE;
        ISSUE:   if (alu_ready) w_state_next = WAIT_A;
        default:                w_state_next = WAIT_A;
      endcase
    end
  end

  // Capture strobes; presses in ISSUE fall through all three and are dropped.
  always_comb begin
    op_valid = 1'b0;
    stage    = r_state;
    w_cap_a  = 1'b0;
    w_cap_b  = 1'b0;
    w_cap_op = 1'b0;
    case (r_state)
      WAIT_A:  w_cap_a  = w_press & ~clear;
      WAIT_B:  w_cap_b  = w_press & ~clear;
      WAIT_OP: w_cap_op = w_press & ~clear;
      ISSUE:   op_valid = 1'b1;
      default: ;
    endcase
  end

  // Captured values persist past the handshake so downstream flags stay displayable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_opcode <= '0;
    end else if (clear) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_opcode <= '0;
    end else begin
      if (w_cap_a)  r_op_a   <= sw_data;
      if (w_cap_b)  r_op_b   <= sw_data;
      if (w_cap_op) r_opcode <= sw_data[OPW-1:0];
    end
  end

  assign op_a   = r_op_a;
  assign op_b   = r_op_b;
  assign opcode = r_opcode;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader (default build): a reference model derived from the
// capture-latency and sequencing rules is compared every cycle, plus literal spot checks.
module tb_alu_operand_loader;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_data;
  logic       btn_load;
  logic       clear;
  logic       alu_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] opcode;
  logic       op_valid;
  logic [1:0] stage;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 0;

  alu_operand_loader #(.N(4), .OPW(4), .DEB_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_data  (sw_data),
    .btn_load (btn_load),
    .clear    (clear),
    .alu_ready(alu_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .opcode   (opcode),
    .op_valid (op_valid),
    .stage    (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. btn_seen[k] is the raw button level sampled at the k-th edge back;
  // a capture happens two edges after the first edge that saw a new rise.
  logic [3:0] m_a, m_b, m_op;
  int         m_stage;
  bit         btn_seen [1:3];
  bit         m_press;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
      btn_seen[1] = 0; btn_seen[2] = 0; btn_seen[3] = 0;
    end else begin
      m_press = btn_seen[2] && !btn_seen[3];
      if (clear) begin
        m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
      end else if (m_stage == 0 && m_press) begin
        m_a = sw_data; m_stage = 1;
      end else if (m_stage == 1 && m_press) begin
        m_b = sw_data; m_stage = 2;
      end else if (m_stage == 2 && m_press) begin
        m_op = sw_data; m_stage = 3;
      end else if (m_stage == 3 && alu_ready) begin
        m_stage = 0;
      end
      btn_seen[3] = btn_seen[2];
      btn_seen[2] = btn_seen[1];
      btn_seen[1] = btn_load;
    end
  end

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle", {17'd0, op_a, op_b, opcode, op_valid, stage},
            {17'd0, m_a, m_b, m_op, (m_stage == 3), 2'(m_stage)});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full press: switches change afterwards to show only the capture-edge value counts.
  task automatic press(input logic [3:0] val);
    sw_data  = val;
    btn_load = 1'b1;
    tick(4);
    btn_load = 1'b0;
    sw_data  = ~val;
    tick(3);
  endtask

  task automatic handshake();
    alu_ready = 1'b1;
    tick(1);
    alu_ready = 1'b0;
  endtask

  initial begin
    rst_n = 0; sw_data = 0; btn_load = 0; clear = 0; alu_ready = 0;
    #23;
    check("reset_valid", op_valid, 1'b0);
    check("reset_stage", stage, 2'd0);
    check("reset_ops", {op_a, op_b, opcode}, 12'h000);
    @(negedge clk);
    rst_n  = 1;
    cmp_en = 1;
    alu_ready = 1'b1;  // outside ISSUE this must do nothing
    tick(3);
    alu_ready = 1'b0;

    // Basic load
    press(4'hA); press(4'h6); press(4'h0);
    check("load_a", op_a, 4'hA);
    check("load_b", op_b, 4'h6);
    check("load_op", opcode, 4'h0);
    check("load_valid", op_valid, 1'b1);
    check("load_stage", stage, 2'd3);
    tick(5);
    check("hold_set", {op_a, op_b, opcode, op_valid, stage}, {4'hA, 4'h6, 4'h0, 1'b1, 2'd3});
    handshake();
    check("xfer_valid", op_valid, 1'b0);
    check("xfer_stage", stage, 2'd0);
    check("xfer_keep_a", op_a, 4'hA);

    // Latency/hold: raised before edge k, capture exactly at edge k+2, only once
    sw_data = 4'h5; btn_load = 1'b1;
    tick(1);
    check("lat_k", {op_a, stage}, {4'hA, 2'd0});
    tick(1);
    check("lat_k1", {op_a, stage}, {4'hA, 2'd0});
    tick(1);
    check("lat_k2", {op_a, stage}, {4'h5, 2'd1});
    sw_data = 4'h9;
    tick(17);
    check("held_once", {op_a, op_b, stage}, {4'h5, 4'h6, 2'd1});
    btn_load = 1'b0;
    tick(3);

    // Ignored press in ISSUE
    press(4'h3); press(4'h7);
    check("issue_stage", stage, 2'd3);
    press(4'hF);
    check("ignored", {op_a, op_b, opcode, stage}, {4'h5, 4'h3, 4'h7, 2'd3});
    handshake();
    press(4'hF);
    check("after_ignored", {op_a, stage}, {4'hF, 2'd1});

    // clear coincident with a press in WAIT_OP
    press(4'h2);
    check("pre_clear", stage, 2'd2);
    sw_data = 4'hB; btn_load = 1'b1;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_all", {op_a, op_b, opcode, op_valid, stage}, 15'd0);
    tick(6);  // button still held across clear: no new capture
    check("clear_held", {op_a, stage}, {4'h0, 2'd0});
    btn_load = 1'b0;
    tick(3);

    // Async reset mid-cycle while in ISSUE
    press(4'h9); press(4'h1); press(4'h2);
    check("pre_rst", {op_valid, stage}, {1'b1, 2'd3});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", op_valid, 1'b0);
    check("arst_stage", stage, 2'd0);
    check("arst_ops", {op_a, op_b, opcode}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    press(4'hC);
    check("post_rst_a", {op_a, stage}, {4'hC, 2'd1});
    tick(2);

    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
